temp_sense: RTL and testbench
=============================

Name: temp_sense

Overview:
- Front-end stage directly upstream of the thermostat controller; produces the filtered temperature and the t_g_gt flag that the controller consumes alongside the goal temperature gt.
- Drives a serial 8-bit ADC (CS / SCLK / DO, one null bit then 8 data bits MSB first).
- Averages 2^AVG_LOG2 conversions and registers a comparison of the averaged temperature against gt.

Parameters:
CLK_DIV, 8, clk cycles per SCLK half-period (tick period); legal range 2..255
AVG_LOG2, 2, log2 of samples averaged per output; legal range 0..4
SAMPLE_GAP, 16, ticks with adc_cs_n high between conversions; minimum 1
HYST, 2, hysteresis band in LSBs; used only when GT_HYST_EN is defined

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en  input  1  conversion enable
gt  input  8  goal temperature, same encoding as t
adc_do  input  1  ADC serial data
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock
t  output  8  averaged temperature
t_valid  output  1  one-cycle strobe; t and t_g_gt updated in this cycle
t_g_gt  output  1  temperature greater than goal; held between updates

Behaviour:
- Reset (rst=0, asynchronous): adc_cs_n=1, adc_sclk=0, t=0, t_valid=0, t_g_gt=0. Accumulator, sample count, tick divider and FSM are cleared; FSM goes to IDLE. Asserting reset mid-conversion aborts the frame immediately and discards the partial sum.
- Tick: one-clk pulse every CLK_DIV clk cycles. The divider free-runs out of reset. All FSM and SCLK activity advances only on ticks.
- FSM states:
  - IDLE: if en=1 at a tick, assert adc_cs_n=0 and go to BIT.
  - BIT: each bit uses 2 ticks. On the first tick adc_sclk goes 1 and adc_do is sampled in the same clk. On the second tick adc_sclk goes 0. Bit 0 is the null bit and is discarded; bits 1..8 shift into an 8-bit shift register MSB first. After bit 8's falling tick: adc_cs_n=1, go to DONE.
  - Frame length: adc_cs_n low for exactly 18 ticks (18*CLK_DIV clk) with exactly 9 SCLK rising edges.
  - DONE (1 clk): add the sample into the accumulator (8+AVG_LOG2 bits, cannot overflow) and increment the sample count. When the count reaches 2^AVG_LOG2:
    - t <= acc >> AVG_LOG2 (truncating).
    - t_g_gt is updated per the comparison rule.
    - t_valid=1 for that single clk.
    - Accumulator and count are cleared.
    - Then go to GAP.
  - GAP: wait SAMPLE_GAP ticks with adc_cs_n=1, then go to IDLE.
- en: sampled only in IDLE. Dropping en mid-frame lets the frame finish and accumulate normally. The partial average is retained across en-low periods.
- Comparison (without hysteresis): t_g_gt <= (new_t > gt), unsigned, using gt as it is in the t_valid cycle. Changes to gt between strobes do not affect t_g_gt.
- adc_sclk and adc_cs_n are driven directly from flops (glitch-free).

Optional Feature:
GT_HYST_EN:
- Defined: t_g_gt sets only when new_t > sat(gt+HYST) and clears only when new_t < sat(gt-HYST). Bounds saturate to 255 and 0 respectively. Otherwise t_g_gt holds its previous value.
- Undefined: HYST is ignored and plain comparison applies.

Test Plan:
1. CLK_DIV=2, AVG_LOG2=2, ADC model always returns 0x5A, gt=0x50, en=1 -> exactly one t_valid after the 4th frame; t=0x5A, t_g_gt=1; t_valid high for exactly 1 clk.
2. ADC returns 10,11,12,13 -> t=11 (sum 46 truncated); gt=11 -> t_g_gt=0 (equal is not greater).
3. Frame timing, CLK_DIV=2 -> adc_cs_n low for 36 clk; 9 adc_sclk rising edges; null bit driven to 1 by the model does not appear in t; adc_cs_n high for SAMPLE_GAP*2 clk between frames.
4. GT_HYST_EN, HYST=2, AVG_LOG2=0, gt=100, t sequence 101,103,99,97 -> t_g_gt 0,1,1,0. Repeat without macro -> 1,1,0,0.
5. GT_HYST_EN, gt=254, t=255 -> set bound saturates at 255, t_g_gt stays 0. Then gt=1, t=0 -> clear bound saturates at 0; a t_g_gt of 1 stays 1.
6. rst pulsed low during bit 5 of frame 3 -> adc_cs_n=1 and t=0 asynchronously. After release, the first t_valid comes only after 4 complete new frames. Separately, en dropped mid-frame 2 -> frame 2 completes, no further adc_cs_n fall until en=1; the next t_valid follows 2 more frames.

Source files
------------

// File: rtl/temp_sense.sv
// temp_sense: serial 8-bit ADC front end. Runs CS/SCLK conversion frames,
// averages 2**AVG_LOG2 samples into t and registers t > gt as t_g_gt.
// Optional macro GT_HYST_EN: apply a +/-HYST band to the t_g_gt decision.
module temp_sense #(
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned SAMPLE_GAP = 16,
    parameter int unsigned HYST       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] gt,
    input  logic       adc_do,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] t,
    output logic       t_valid,
    output logic       t_g_gt
);

    localparam int unsigned ACC_W = 8 + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] NSAMP    = CNT_W'(2 ** AVG_LOG2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("temp_sense: CLK_DIV must be in 2..255");
    end
    if (AVG_LOG2 > 4) begin : g_bad_avg_log2
        $error("temp_sense: AVG_LOG2 must be in 0..4");
    end
    if (SAMPLE_GAP < 1) begin : g_bad_sample_gap
        $error("temp_sense: SAMPLE_GAP must be at least 1");
    end
    if (HYST > 255) begin : g_bad_hyst
        $error("temp_sense: HYST must fit in 8 bits");
    end

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        DONE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       div_q;
    logic             tick;
    logic [3:0]       bit_q, bit_d;
    logic             phase_q, phase_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             cs_d, sclk_d;
    logic [7:0]       sr_q, sr_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
    logic [7:0]       t_d, new_t;
    logic             tv_d, tg_d, gt_flag;
`ifdef GT_HYST_EN
    logic [8:0]       hi_sum;
    logic [7:0]       hi_bnd, lo_bnd;
`endif

    assign tick = (div_q == DIV_LAST);

    // Free-running tick divider: one tick every CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

    // State and datapath registers; ADC pins come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            gap_q    <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            t        <= '0;
            t_valid  <= 1'b0;
            t_g_gt   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            gap_q    <= gap_d;
            adc_cs_n <= cs_d;
            adc_sclk <= sclk_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            t        <= t_d;
            t_valid  <= tv_d;
            t_g_gt   <= tg_d;
        end
    end

    // Next-state, frame sequencing, accumulation and goal comparison.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        cs_d    = adc_cs_n;
        sclk_d  = adc_sclk;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        t_d     = t;
        tv_d    = 1'b0;
        tg_d    = t_g_gt;

        acc_sum = acc_q + ACC_W'(sr_q);
        cnt_sum = cnt_q + CNT_W'(1);
        new_t   = 8'(acc_sum >> AVG_LOG2);

`ifdef GT_HYST_EN
        hi_sum  = {1'b0, gt} + 9'(HYST);
        hi_bnd  = hi_sum[8] ? 8'hFF : hi_sum[7:0];
        lo_bnd  = ({1'b0, gt} > 9'(HYST)) ? 8'({1'b0, gt} - 9'(HYST)) : '0;
        if (new_t > hi_bnd) begin
            gt_flag = 1'b1;
        end else if (new_t < lo_bnd) begin
            gt_flag = 1'b0;
        end else begin
            gt_flag = t_g_gt;
        end
`else
        gt_flag = (new_t > gt);
`endif

        case (state_q)
            IDLE: begin
                if (tick && en) begin
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = BIT;
                end
            end
            BIT: begin
                if (tick) begin
                    if (!phase_q) begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                        if (bit_q != 4'd0) begin
                            sr_d = {sr_q[6:0], adc_do};
                        end
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q == 4'd8) begin
                            cs_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (cnt_sum == NSAMP) begin
                    t_d   = new_t;
                    tg_d  = gt_flag;
                    tv_d  = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_sum;
                end
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                // The tick that closes the gap doubles as the IDLE decision
                // tick, so CS stays high for exactly SAMPLE_GAP ticks.
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        if (en) begin
                            cs_d    = 1'b0;
                            bit_d   = '0;
                            phase_d = 1'b0;
                            state_d = BIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_temp_sense.sv
// tb_temp_sense: directed checks of temp_sense conversion framing, averaging,
// goal comparison (plain or GT_HYST_EN), reset abort and enable handling.
module tb_temp_sense;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, en1;
    logic [7:0] gt, gt1;
    logic       adc_do  = 1'b1;
    logic       adc_do1 = 1'b1;
    logic       cs_n, sclk, tv, tg;
    logic       cs_n1, sclk1, tv1, tg1;
    logic [7:0] t, t1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    temp_sense #(.CLK_DIV(2), .AVG_LOG2(2), .SAMPLE_GAP(4), .HYST(2)) dut (
        .clk(clk), .rst(rst), .en(en), .gt(gt), .adc_do(adc_do),
        .adc_cs_n(cs_n), .adc_sclk(sclk), .t(t), .t_valid(tv), .t_g_gt(tg)
    );

    temp_sense #(.CLK_DIV(2), .AVG_LOG2(0), .SAMPLE_GAP(1), .HYST(2)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .gt(gt1), .adc_do(adc_do1),
        .adc_cs_n(cs_n1), .adc_sclk(sclk1), .t(t1), .t_valid(tv1), .t_g_gt(tg1)
    );

    // ADC models: null bit driven 1, then the frame word MSB first, each bit
    // presented after the preceding SCLK falling edge.
    logic [7:0]  seq0 [8];
    logic [7:0]  seq1 [8];
    int unsigned seq0_len = 1, seq0_base = 0, falls0 = 0, rises0 = 0, bit0 = 9;
    int unsigned seq1_len = 1, seq1_base = 0, falls1 = 0, bit1 = 9;
    logic [7:0]  word0 = '0, word1 = '0;

    always @(negedge cs_n) begin
        word0  = seq0[(falls0 - seq0_base) % seq0_len];
        falls0 = falls0 + 1;
        bit0   = 0;
        adc_do = 1'b1;
    end
    always @(negedge sclk) begin
        if (bit0 < 8) begin
            bit0   = bit0 + 1;
            adc_do = word0[8-bit0];
        end
    end
    always @(posedge cs_n) rises0 = rises0 + 1;

    always @(negedge cs_n1) begin
        word1   = seq1[(falls1 - seq1_base) % seq1_len];
        falls1  = falls1 + 1;
        bit1    = 0;
        adc_do1 = 1'b1;
    end
    always @(negedge sclk1) begin
        if (bit1 < 8) begin
            bit1    = bit1 + 1;
            adc_do1 = word1[8-bit1];
        end
    end

    task automatic wait_tv0(input int unsigned maxc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (tv === 1'b1) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_tv1(input int unsigned maxc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (tv1 === 1'b1) ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; en1 = 1'b0; gt = '0; gt1 = '0;
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (t !== 8'h00) begin errors++; $display("FAIL reset_t got %h want 00", t); end
        checks++; if (tv !== 1'b0) begin errors++; $display("FAIL reset_t_valid got %b want 0", tv); end
        checks++; if (tg !== 1'b0) begin errors++; $display("FAIL reset_t_g_gt got %b want 0", tg); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Single-sample averaging: each frame strobes, exercising the comparison.
    task automatic test_compare;
        logic [7:0] vals [7];
        logic [7:0] gts  [7];
        logic       exp  [7];
        bit         ok;
        vals = '{8'd101, 8'd103, 8'd99, 8'd97, 8'd255, 8'd5, 8'd0};
        gts  = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd254, 8'd1, 8'd1};
`ifdef GT_HYST_EN
        exp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 7; i++) seq1[i] = vals[i];
        seq1_len  = 7;
        seq1_base = falls1;
        gt1 = gts[0];
        en1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            gt1 = gts[i];
            wait_tv1(200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL cmp_strobe[%0d] no t_valid within 200 clk", i); end
            checks++; if (t1 !== vals[i]) begin errors++; $display("FAIL cmp_t[%0d] got %0d want %0d", i, t1, vals[i]); end
            checks++; if (tg1 !== exp[i]) begin errors++; $display("FAIL cmp_t_g_gt[%0d] got %b want %b", i, tg1, exp[i]); end
        end
        en1 = 1'b0;
    endtask

    task automatic test_average;
        bit          ok;
        int unsigned base;
        seq0[0] = 8'h5A; seq0_len = 1; seq0_base = falls0;
        gt = 8'h50;
        base = rises0;
        en = 1'b1;
        wait_tv0(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL avg_strobe no t_valid within 600 clk"); end
        checks++; if (rises0 - base !== 4) begin errors++; $display("FAIL avg_frames got %0d want 4", rises0 - base); end
        checks++; if (t !== 8'h5A) begin errors++; $display("FAIL avg_t got %h want 5a", t); end
        checks++; if (tg !== 1'b1) begin errors++; $display("FAIL avg_t_g_gt got %b want 1", tg); end
        @(negedge clk);
        checks++; if (tv !== 1'b0) begin errors++; $display("FAIL avg_strobe_width t_valid got %b want 0", tv); end
    endtask

    task automatic test_truncate;
        bit          ok;
        int unsigned base;
        seq0[0] = 8'd10; seq0[1] = 8'd11; seq0[2] = 8'd12; seq0[3] = 8'd13;
        seq0_len = 4; seq0_base = falls0;
        gt = 8'd11;
        base = rises0;
        wait_tv0(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL trunc_strobe no t_valid within 600 clk"); end
        checks++; if (rises0 - base !== 4) begin errors++; $display("FAIL trunc_frames got %0d want 4", rises0 - base); end
        checks++; if (t !== 8'd11) begin errors++; $display("FAIL trunc_t got %0d want 11", t); end
        checks++; if (tg !== 1'b0) begin errors++; $display("FAIL trunc_t_g_gt got %b want 0", tg); end
    endtask

    task automatic test_frame_timing;
        int unsigned n = 0, lowc = 0, highc = 0, rc = 0;
        logic        prev;
        seq0[0] = 8'h5A; seq0_len = 1; seq0_base = falls0;
        while (cs_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL timing_start adc_cs_n got %b want 0", cs_n); end
        prev = sclk;
        n = 0;
        while (cs_n === 1'b0 && n < 200) begin
            lowc++;
            if (sclk === 1'b1 && prev === 1'b0) rc++;
            prev = sclk;
            @(negedge clk);
            n++;
        end
        n = 0;
        while (cs_n === 1'b1 && n < 200) begin highc++; @(negedge clk); n++; end
        checks++; if (lowc !== 36) begin errors++; $display("FAIL timing_cs_low got %0d clk want 36", lowc); end
        checks++; if (rc !== 9) begin errors++; $display("FAIL timing_sclk_rises got %0d want 9", rc); end
        checks++; if (highc !== 8) begin errors++; $display("FAIL timing_cs_gap got %0d clk want 8", highc); end
    endtask

    task automatic test_reset_abort;
        bit          ok;
        int unsigned base, n = 0, rc = 0;
        logic        prev;
        seq0[0] = 8'h40; seq0_len = 1; seq0_base = falls0;
        base = falls0;
        while (falls0 - base < 3 && n < 600) begin @(negedge clk); n++; end
        checks++; if (falls0 - base !== 3) begin errors++; $display("FAIL abort_frame3 falls got %0d want 3", falls0 - base); end
        prev = sclk;
        n = 0;
        while (rc < 6 && n < 100) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev === 1'b0) rc++;
            prev = sclk;
            n++;
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n got %b want 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b want 0", sclk); end
        checks++; if (t !== 8'h00) begin errors++; $display("FAIL abort_t got %h want 00", t); end
        checks++; if (tg !== 1'b0) begin errors++; $display("FAIL abort_t_g_gt got %b want 0", tg); end
        @(negedge clk);
        rst = 1'b1;
        seq0[0] = 8'h20; seq0_base = falls0;
        base = rises0;
        wait_tv0(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_strobe no t_valid within 600 clk"); end
        checks++; if (rises0 - base !== 4) begin errors++; $display("FAIL abort_frames got %0d want 4", rises0 - base); end
        checks++; if (t !== 8'h20) begin errors++; $display("FAIL abort_t_after got %h want 20", t); end
    endtask

    task automatic test_en_drop;
        bit          ok;
        int unsigned base, fbase, n = 0, rc = 0, stray = 0;
        logic        prev;
        seq0[0] = 8'h10; seq0[1] = 8'h10; seq0[2] = 8'h30; seq0[3] = 8'h30;
        seq0_len = 4; seq0_base = falls0;
        fbase = falls0;
        while (falls0 - fbase < 2 && n < 300) begin @(negedge clk); n++; end
        prev = sclk;
        n = 0;
        while (rc < 3 && n < 100) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev === 1'b0) rc++;
            prev = sclk;
            n++;
        end
        en = 1'b0;
        base = rises0;
        n = 0;
        while (rises0 == base && n < 100) begin @(negedge clk); n++; end
        checks++; if (rises0 - base !== 1) begin errors++; $display("FAIL endrop_frame_done rises got %0d want 1", rises0 - base); end
        fbase = falls0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1) stray++;
        end
        checks++; if (falls0 - fbase !== 0) begin errors++; $display("FAIL endrop_idle cs falls got %0d want 0", falls0 - fbase); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL endrop_cs_high low samples got %0d want 0", stray); end
        base = rises0;
        en = 1'b1;
        wait_tv0(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_strobe no t_valid within 400 clk"); end
        checks++; if (rises0 - base !== 2) begin errors++; $display("FAIL endrop_frames got %0d want 2", rises0 - base); end
        checks++; if (t !== 8'h20) begin errors++; $display("FAIL endrop_t got %h want 20", t); end
    endtask

    initial begin
        test_reset;
        test_compare;
        test_average;
        test_truncate;
        test_frame_timing;
        test_reset_abort;
        test_en_drop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
